// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx
// Write-only I2C target receiver. Oversamples scl/sda on clk, detects
// START / repeated START / STOP, matches a 7-bit address, ACKs accepted
// bytes and hands each data byte to local logic over valid/ready.
//
// Optional feature macro: I2C_RX_GLITCH_FILTER_EN
//   defined   -> each synchronized line passes a FILTER_LEN-sample
//                stability filter before edge detection
//   undefined -> no filter, events 3 clk after the pins change
//
// Ports:
//   clk        in   system clock (>= 8x SCL rate)
//   reset      in   asynchronous active-low reset
//   scl        in   bus clock from the master
//   sda_in     in   bus data as seen on the wire
//   sda_oe     out  1 = pull sda low (ACK), 0 = release
//   data_out   out  last accepted data byte, MSB received first
//   data_valid out  data_out holds an unconsumed byte
//   data_ready in   consumer takes data_out when data_valid && data_ready
//   busy       out  high from address match until STOP, Sr or NACK
//   overrun    out  1-clk pulse when a byte completes while data_valid is high
module i2c_slave_rx #(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       overrun
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    // Legal FILTER_LEN is 2..8; an out-of-range value shows up as this
    // named block in the elaborated hierarchy.
    if ((FILTER_LEN < 32'sd2) || (FILTER_LEN > 32'sd8)) begin : g_filter_len_out_of_range
    end

    // Bit 1 carries scl, bit 0 carries sda through the whole input path.
    logic [1:0] meta_r;
    logic [1:0] sync_r;
    logic [1:0] line_s;
    logic [1:0] prev_r;

    // Two-flop synchronizer; idle bus level is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 2'b11;
            sync_r <= 2'b11;
        end else begin
            meta_r <= {scl, sda_in};
            sync_r <= meta_r;
        end
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 32'sd1);
    logic [1:0] filt_r;
    logic [3:0] flt_cnt_r [2];

    // Stability filter: a new level is taken only after FILTER_LEN
    // consecutive samples disagree with the current filtered level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_r       <= 2'b11;
            flt_cnt_r[0] <= 4'd0;
            flt_cnt_r[1] <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == filt_r[i]) begin
                    flt_cnt_r[i] <= 4'd0;
                end else if (flt_cnt_r[i] == FLT_LAST) begin
                    filt_r[i]    <= sync_r[i];
                    flt_cnt_r[i] <= 4'd0;
                end else begin
                    flt_cnt_r[i] <= flt_cnt_r[i] + 4'd1;
                end
            end
        end
    end

    assign line_s = filt_r;
`else
    assign line_s = sync_r;
`endif

    // Previous-value stage feeding edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r <= 2'b11;
        end else begin
            prev_r <= line_s;
        end
    end

    logic scl_cur_s, sda_cur_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    assign scl_cur_s  = line_s[1];
    assign sda_cur_s  = line_s[0];
    assign scl_rise_s = scl_cur_s & ~prev_r[1];
    assign scl_fall_s = ~scl_cur_s & prev_r[1];
    // scl must be high on both samples so an sda change made together
    // with a falling scl is never taken for START/STOP.
    assign start_s    = scl_cur_s & prev_r[1] & prev_r[0] & ~sda_cur_s;
    assign stop_s     = scl_cur_s & prev_r[1] & ~prev_r[0] & sda_cur_s;

    logic [2:0] state_r, state_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic       byte_done_r, byte_done_s;
    logic       ack_armed_r, ack_armed_s;
    logic       sda_oe_r, sda_oe_s;
    logic       busy_r, busy_s;
    logic [7:0] data_out_r, data_out_s;
    logic       data_valid_r, data_valid_s;
    logic       overrun_r, overrun_s;

    // Next-state logic for the receive FSM and its registered outputs.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        byte_done_s = byte_done_r;
        ack_armed_s = ack_armed_r;
        sda_oe_s    = sda_oe_r;
        busy_s      = busy_r;
        data_out_s  = data_out_r;
        overrun_s   = 1'b0;
        if (data_valid_r && data_ready) begin
            data_valid_s = 1'b0;
        end else begin
            data_valid_s = data_valid_r;
        end

        if (start_s || stop_s) begin
            // Bus conditions win over everything; partial byte is dropped.
            state_s     = start_s ? ST_ADDR : ST_IDLE;
            bit_cnt_s   = 3'd0;
            shift_s     = 8'h00;
            byte_done_s = 1'b0;
            sda_oe_s    = 1'b0;
            busy_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_s     = {shift_r[6:0], sda_cur_s};
                        bit_cnt_s   = bit_cnt_r + 3'd1;
                        byte_done_s = (bit_cnt_r == 3'd7);
                    end else if (scl_fall_s && byte_done_r) begin
                        byte_done_s = 1'b0;
                        if (shift_r == {ADDR, 1'b0}) begin
                            state_s  = ST_ADDR_ACK;
                            sda_oe_s = 1'b1;
                            busy_s   = 1'b1;
                        end else begin
                            state_s  = ST_IGNORE;
                        end
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_s = 1'b0;
                        state_s  = ST_DATA;
                    end else begin
                        state_s  = ST_ADDR_ACK;
                    end
                end
                ST_DATA: begin
                    if (scl_rise_s) begin
                        shift_s   = {shift_r[6:0], sda_cur_s};
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            byte_done_s = 1'b1;
                            // A byte consumed this very cycle frees the slot.
                            if (!data_valid_r || data_ready) begin
                                data_out_s   = {shift_r[6:0], sda_cur_s};
                                data_valid_s = 1'b1;
                                ack_armed_s  = 1'b1;
                            end else begin
                                overrun_s    = 1'b1;
                                ack_armed_s  = 1'b0;
                            end
                        end else begin
                            byte_done_s = 1'b0;
                        end
                    end else if (scl_fall_s && byte_done_r) begin
                        byte_done_s = 1'b0;
                        state_s     = ST_DATA_ACK;
                        sda_oe_s    = ack_armed_r;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_s = 1'b0;
                        if (ack_armed_r) begin
                            state_s = ST_DATA;
                        end else begin
                            state_s = ST_IGNORE;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        state_s = ST_DATA_ACK;
                    end
                end
                ST_IGNORE: begin
                    sda_oe_s = 1'b0;
                end
                default: begin
                    state_s  = ST_IDLE;
                    sda_oe_s = 1'b0;
                    busy_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_done_r  <= 1'b0;
            ack_armed_r  <= 1'b0;
            sda_oe_r     <= 1'b0;
            busy_r       <= 1'b0;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            byte_done_r  <= byte_done_s;
            ack_armed_r  <= ack_armed_s;
            sda_oe_r     <= sda_oe_s;
            busy_r       <= busy_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            overrun_r    <= overrun_s;
        end
    end

    assign sda_oe     = sda_oe_r;
    assign busy       = busy_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: drives I2C write/read transactions at a slow
// SCL rate and checks the receiver against a transaction-level model of
// what the target must do (ACK/NACK, busy, held byte, delivered bytes,
// overruns).
module tb_i2c_slave_rx;

    localparam int         Q        = 12;      // clk cycles per SCL quarter
    localparam logic [6:0] DUT_ADDR = 7'h50;

    logic       clk_s = 1'b0;
    logic       reset_s, scl_s, sda_m_s, data_ready_s;
    logic       sda_in_s, sda_oe_s, data_valid_s, busy_s, overrun_s;
    logic [7:0] data_out_s;

    // Open-drain wire: master drive AND target pull-down.
    assign sda_in_s = sda_m_s & ~sda_oe_s;

    i2c_slave_rx #(.ADDR(DUT_ADDR), .FILTER_LEN(3)) dut (
        .clk        (clk_s),
        .reset      (reset_s),
        .scl        (scl_s),
        .sda_in     (sda_in_s),
        .sda_oe     (sda_oe_s),
        .data_out   (data_out_s),
        .data_valid (data_valid_s),
        .data_ready (data_ready_s),
        .busy       (busy_s),
        .overrun    (overrun_s)
    );

    always #5 clk_s = ~clk_s;

    int total_r = 0;
    int bad_r   = 0;

    // Model state
    logic       chk_en    = 1'b0;
    logic       exp_oe    = 1'b0;
    logic       exp_busy  = 1'b0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       mv        = 1'b0;   // byte held and unconsumed
    logic [7:0] md        = 8'h00;  // held byte
    logic       alive     = 1'b0;   // target still taking part in transfer
    int         exp_ovr   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ovr_cnt   = 0;
    int         oe_cnt    = 0;
    logic       ovr_prev  = 1'b0;
    logic [7:0] b_tmp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_r++;
        if (act !== req) begin
            bad_r++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process plus delivery/overrun monitor, away from the active edge.
    always @(negedge clk_s) begin
        if (chk_en) begin
            check("sda_oe", sda_oe_s, exp_oe);
            check("busy", busy_s, exp_busy);
            check("data_valid", data_valid_s, exp_valid);
            if (exp_valid) begin
                check("data_out", data_out_s, exp_data);
            end
        end
        if (data_valid_s && data_ready_s) begin
            got_q.push_back(data_out_s);
        end
        if (overrun_s) begin
            ovr_cnt++;
            check("overrun_width", ovr_prev, 1'b0);
        end
        ovr_prev = overrun_s;
        if (sda_oe_s) begin
            oe_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_s);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic e_oe, input logic e_busy,
                            input logic e_valid, input logic [7:0] e_data, input logic glitch);
        sda_m_s = b;
        if (glitch) begin
            wait_clk(Q / 2);
            scl_s = 1'b1;
            wait_clk(1);
            scl_s = 1'b0;
            wait_clk(Q - Q / 2 - 1);
        end else begin
            wait_clk(Q);
        end
        scl_s = 1'b1;
        wait_clk(Q);
        exp_oe    = e_oe;
        exp_busy  = e_busy;
        exp_valid = e_valid;
        exp_data  = e_data;
        chk_en    = 1'b1;
        wait_clk(Q);
        chk_en    = 1'b0;
        scl_s     = 1'b0;
        wait_clk(2);
    endtask

    task automatic start_cond();
        sda_m_s = 1'b1;
        wait_clk(Q);
        scl_s = 1'b1;
        wait_clk(Q);
        sda_m_s = 1'b0;
        wait_clk(Q);
        scl_s = 1'b0;
        wait_clk(2);
    endtask

    task automatic stop_cond();
        sda_m_s = 1'b0;
        wait_clk(Q);
        scl_s = 1'b1;
        wait_clk(Q);
        sda_m_s = 1'b1;
        wait_clk(Q);
        alive     = 1'b0;
        exp_oe    = 1'b0;
        exp_busy  = 1'b0;
        exp_valid = mv;
        exp_data  = md;
        chk_en    = 1'b1;
        wait_clk(Q);
        chk_en    = 1'b0;
    endtask

    // START + address byte + ACK slot. Target answers only a write to its address.
    task automatic addr_phase(input logic [6:0] a, input logic rw);
        logic [7:0] ab;
        start_cond();
        ab    = {a, rw};
        alive = (a == DUT_ADDR) && (rw == 1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(ab[i], 1'b0, 1'b0, mv, md, 1'b0);
        end
        send_bit(1'b1, alive, alive, mv, md, 1'b0);
    endtask

    // One data byte + ACK slot. glitch_bit selects a bit whose low phase
    // carries a 1-clk scl pulse (-1 for none).
    task automatic data_byte(input logic [7:0] byt, input int glitch_bit);
        logic       alive_old, mv_old, acc;
        logic [7:0] md_old;
        alive_old = alive;
        mv_old    = mv;
        md_old    = md;
        acc       = 1'b0;
        if (alive_old) begin
            acc = data_ready_s || !mv;
            if (acc) begin
                if (data_ready_s) begin
                    exp_q.push_back(byt);
                end else begin
                    mv = 1'b1;
                    md = byt;
                end
            end else begin
                exp_ovr++;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                send_bit(byt[i], 1'b0, alive_old, mv, md, glitch_bit == 0);
            end else begin
                send_bit(byt[i], 1'b0, alive_old, mv_old, md_old, glitch_bit == i);
            end
        end
        send_bit(1'b1, alive_old && acc, alive_old, mv, md, 1'b0);
        alive = alive_old && acc;
    endtask

    // First n bits of a byte, leaving the byte unfinished.
    task automatic partial_bits(input logic [7:0] byt, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            send_bit(byt[i], 1'b0, alive, mv, md, 1'b0);
        end
    endtask

    task automatic check_q(input string name);
        int n;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_byte"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_sda_oe"}, sda_oe_s, 1'b0);
        check({name, "_data_out"}, data_out_s, 8'h00);
        check({name, "_data_valid"}, data_valid_s, 1'b0);
        check({name, "_busy"}, busy_s, 1'b0);
        check({name, "_overrun"}, overrun_s, 1'b0);
    endtask

    initial begin
        reset_s      = 1'b0;
        scl_s        = 1'b1;
        sda_m_s      = 1'b1;
        data_ready_s = 1'b1;
        wait_clk(4);
        check_reset_values("reset");
        reset_s = 1'b1;
        wait_clk(4);

        // Write 0x50: A5, 5A with consumer always ready
        addr_phase(7'h50, 1'b0);
        data_byte(8'hA5, -1);
        data_byte(8'h5A, -1);
        stop_cond();
        check("t1_delivered", got_q.size(), 2);
        b_tmp = (got_q.size() > 0) ? got_q[0] : 8'h00;
        check("t1_first", b_tmp, 8'hA5);
        b_tmp = (got_q.size() > 1) ? got_q[1] : 8'h00;
        check("t1_second", b_tmp, 8'h5A);
        check("t1_busy_after_stop", busy_s, 1'b0);
        check_q("t1");

        // Wrong address 0x51
        oe_cnt = 0;
        addr_phase(7'h51, 1'b0);
        data_byte(8'hAA, -1);
        stop_cond();
        check("t2_oe_cycles", oe_cnt, 0);
        check("t2_valid", data_valid_s, 1'b0);
        check_q("t2");

        // Read to 0x50: NACK, bus ignored until next START
        oe_cnt = 0;
        addr_phase(7'h50, 1'b1);
        data_byte(8'h0F, -1);
        check("t3_oe_cycles", oe_cnt, 0);

        // Consumer stalled: 0x55 held, 0x3A overruns (START straight from ignore)
        data_ready_s = 1'b0;
        addr_phase(7'h50, 1'b0);
        data_byte(8'h55, -1);
        data_byte(8'h3A, -1);
        stop_cond();
        check("t4_held", data_out_s, 8'h55);
        check("t4_valid", data_valid_s, 1'b1);
        check("t4_overruns", ovr_cnt, 1);
        data_ready_s = 1'b1;
        exp_q.push_back(md);
        mv = 1'b0;
        wait_clk(4);
        check("t4_valid_cleared", data_valid_s, 1'b0);
        check_q("t4");

        // Repeated START after 4 bits of a data byte
        addr_phase(7'h50, 1'b0);
        partial_bits(8'h96, 4);
        addr_phase(7'h50, 1'b0);
        data_byte(8'hCC, -1);
        stop_cond();
        check_q("t5");

        // Reset mid-byte of 0xBD, then a fresh write
        addr_phase(7'h50, 1'b0);
        partial_bits(8'hBD, 4);
        reset_s = 1'b0;
        wait_clk(3);
        check_reset_values("t6_reset");
        mv    = 1'b0;
        md    = 8'h00;
        alive = 1'b0;
        wait_clk(2);
        reset_s = 1'b1;
        b_tmp = 8'hBD;
        for (int i = 3; i >= 0; i--) begin
            send_bit(b_tmp[i], 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        stop_cond();
        addr_phase(7'h50, 1'b0);
        data_byte(8'hDD, -1);
        stop_cond();
        b_tmp = (got_q.size() > 0) ? got_q[0] : 8'h00;
        check("t6_fresh_byte", b_tmp, 8'hDD);
        check_q("t6");

`ifdef I2C_RX_GLITCH_FILTER_EN
        // 1-clk scl pulse inside a data bit must not add a bit
        addr_phase(7'h50, 1'b0);
        data_byte(8'h96, 4);
        stop_cond();
        check_q("t7_glitch");
`endif

        check("overrun_total", ovr_cnt, exp_ovr);
        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

    initial begin
        #2000000;
        bad_r++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Write-only I2C target receiver that sits directly downstream of `I2C_Master` on the two-wire bus. It oversamples `scl`/`sda` on the system clock and detects START, STOP and repeated START. It matches a 7-bit target address, ACKs accepted bytes by pulling `sda` low, and hands each received data byte to local logic over a valid/ready register interface.

## Interface
- `ADDR`, 7'h50: 7-bit target address this block answers to.
- `FILTER_LEN`, 3: samples a level must be stable before acceptance; used only when the glitch filter is compiled in, legal range 2–8.
- `clk`  in  1  system clock; must be ≥8× the SCL rate.
- `reset`  in  1  asynchronous, active-low reset.
- `scl`  in  1  bus clock from the master.
- `sda_in`  in  1  bus data as seen on the wire.
- `sda_oe`  out  1  1 = pull `sda` low (ACK); 0 = release. Open-drain driver is external.
- `data_out`  out  8  last accepted data byte, MSB received first.
- `data_valid`  out  1  `data_out` holds an unconsumed byte.
- `data_ready`  in  1  consumer accepts `data_out` when `data_valid && data_ready` on a rising `clk` edge.
- `busy`  out  1  high from an address match until STOP, repeated START or NACK.
- `overrun`  out  1  one-cycle pulse when a byte completes while `data_valid` is still high.

## Operation
- Input path: two-flop synchronizer per line, reset to 1, followed by one registered previous-value stage that drives edge detection.
- Bus events are defined on synchronized levels:
  - START / repeated START: `sda` falls while `scl` = 1.
  - STOP: `sda` rises while `scl` = 1.
  - Bit sample: rising `scl`.
  - Drive change: falling `scl`.
- State machine states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE → ADDR on START. Clears the 3-bit bit counter and the shift register.
- ADDR: shifts 8 bits (7 address bits, then R/W) on rising `scl`.
  - On the falling `scl` after bit 8:
    - address = `ADDR` and R/W = 0: → ADDR_ACK, set `sda_oe` = 1, set `busy` = 1.
    - any other address or R/W: → IGNORE, `sda_oe` stays 0 (NACK).
- ADDR_ACK: on the next falling `scl`, release `sda_oe` and go → DATA.
- DATA: shifts 8 bits.
  - On the rising `scl` that samples bit 8:
    - `data_valid` = 0, or `data_ready` = 1 in the same cycle: load `data_out`, set `data_valid`, arm ACK.
    - otherwise: drop the byte, pulse `overrun`, arm NACK.
  - On the following falling `scl`: → DATA_ACK, with `sda_oe` = 1 only if ACK is armed.
- DATA_ACK: on the next falling `scl`:
  - after ACK: release `sda_oe` and go → DATA.
  - after NACK: → IGNORE and clear `busy`.
- IGNORE: `sda_oe` = 0; waits for START (→ ADDR) or STOP (→ IDLE).
- START or STOP in any state overrides everything else that cycle: `sda_oe` = 0, `busy` = 0, bit counter cleared. A partial byte is discarded and `data_valid` is untouched.
- `data_valid` clears on the cycle after `data_valid && data_ready` unless a new byte loads in that same cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately and the state goes to IDLE. A transfer already in progress is ignored until the next START.

## Timing
- Reset values:
  - `sda_oe` = 0, `data_out` = 8'h00, `data_valid` = 0, `busy` = 0, `overrun` = 0, state = IDLE.
- Pin-to-event latency is 3 `clk` cycles: 2 synchronizer stages + 1 edge register.
- `data_valid` rises 1 `clk` after the internal bit-8 sample event.
- `sda_oe` asserts 1 `clk` after the internal falling-`scl` event and holds for exactly one SCL low/high period.
- `overrun` is exactly 1 `clk` wide.
- `data_ready` may be held high permanently; the block then never overruns.

## Configuration
- `I2C_RX_GLITCH_FILTER_EN` defined:
  - each synchronized line passes through a `FILTER_LEN`-sample stability filter before edge detection.
  - Pulses shorter than `FILTER_LEN` clk are suppressed.
  - Event latency becomes 3 + `FILTER_LEN` cycles.
  - Filter outputs reset to 1.
- Not defined: no filter; a single-cycle glitch is treated as a real edge; latency is 3 cycles.

## Test plan
- Write to 0x50 with bytes 0xA5, 0x5A, `data_ready` = 1 → ACK on address and both bytes; `data_out` shows 0xA5 then 0x5A, one `data_valid` each; `busy` drops on STOP.
- Write to address 0x51 with byte 0xAA → `sda_oe` never asserts; `data_valid` stays 0; `busy` stays 0.
- Read to 0x50 (R/W = 1) → NACK; block ignores the bus until the next START.
- Write 0x55, 0x3A with `data_ready` = 0 → 0x55 ACKed and held; 0x3A NACKed; one `overrun` pulse; `data_out` stays 0x55.
- Repeated START after 4 bits of a data byte, then write 0x50 / 0xCC → partial byte discarded; 0xCC delivered and ACKed.
- Assert `reset` low mid-byte of 0xBD → all outputs at reset values; after release a fresh write 0x50 / 0xDD delivers 0xDD. With `I2C_RX_GLITCH_FILTER_EN`, a 1-cycle `scl` glitch mid-byte causes no extra bit shift.
